// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 burst scheduler.
package prbs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESTART,
      WAIT,
      RUN,
      DONE
   } state_t;

   localparam int RESTART_CYCLES = 2;
   localparam int PATTERN_W      = 32;
   localparam int N_W            = 4;
   localparam int BYTE_W         = 8;

endpackage

// File: rtl/prbs_rr_arbiter.sv
// Combinational round-robin winner search starting one past the last-grant pointer.
module prbs_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_rot;
   int                 w_first;

   always_comb begin
      // Rotate so that bit 0 is the requester right after the pointer.
      w_rot   = NUM_REQ'({i_req_valid, i_req_valid} >> (int'(i_ptr) + 1));
      w_first = 0;
      o_any   = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_first = j;
            o_any   = 1'b1;
         end
      end
      o_idx   = IDX_W'((int'(i_ptr) + 1 + w_first) % NUM_REQ);
      o_grant = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         o_grant[j] = o_any && (o_idx == IDX_W'(j));
      end
   end

endmodule

// File: rtl/prbs_burst_sched.sv
// Round-robin burst scheduler sharing one PRBS-15 datapath between requesters.
// Optional abort input enabled by defining PRBS_BURST_SCHED_ABORT_EN.
module prbs_burst_sched
   import prbs_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int LEN_W    = 16,
   parameter int PIPE_LAT = 1,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [PATTERN_W*NUM_REQ-1:0] i_req_pattern,
   input  logic [N_W*NUM_REQ-1:0]       i_req_n,
   input  logic [LEN_W*NUM_REQ-1:0]     i_req_len,
`ifdef PRBS_BURST_SCHED_ABORT_EN
   input  logic                         i_abort,
`endif
   input  logic [BYTE_W-1:0]            i_blk_data,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic                         o_blk_rst,
   output logic [PATTERN_W-1:0]         o_blk_pattern,
   output logic [N_W-1:0]               o_blk_n,
   output logic                         o_out_valid,
   output logic [BYTE_W-1:0]            o_out_data,
   output logic [IDX_W-1:0]             o_out_id,
   output logic                         o_out_last,
   output logic                         o_done,
   output logic                         o_busy
);

   localparam int RST_W  = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
   localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESTART_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   logic [PATTERN_W-1:0] w_pat [NUM_REQ];
   logic [N_W-1:0]       w_n   [NUM_REQ];
   logic [LEN_W-1:0]     w_len [NUM_REQ];
   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_any;
   logic                 w_abort;

   state_t               r_state;
   logic [IDX_W-1:0]     r_ptr;
   logic [LEN_W-1:0]     r_len_cnt;
   logic [RST_W-1:0]     r_rst_cnt;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [NUM_REQ-1:0]   r_req_ready;
   logic                 r_blk_rst;
   logic [PATTERN_W-1:0] r_blk_pattern;
   logic [N_W-1:0]       r_blk_n;
   logic                 r_out_valid;
   logic [BYTE_W-1:0]    r_out_data;
   logic [IDX_W-1:0]     r_out_id;
   logic                 r_out_last;
   logic                 r_done;
   logic                 r_busy;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_pat[gi] = i_req_pattern[gi*PATTERN_W +: PATTERN_W];
         assign w_n[gi]   = i_req_n[gi*N_W +: N_W];
         assign w_len[gi] = i_req_len[gi*LEN_W +: LEN_W];
      end
   endgenerate

`ifdef PRBS_BURST_SCHED_ABORT_EN
   assign w_abort = i_abort;
`else
   assign w_abort = 1'b0;
`endif

   prbs_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req_valid (i_req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_idx       (w_idx),
      .o_any       (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_ptr         <= IDX_W'(NUM_REQ - 1);
         r_len_cnt     <= '0;
         r_rst_cnt     <= '0;
         r_wait_cnt    <= '0;
         r_req_ready   <= '0;
         r_blk_rst     <= 1'b1;
         r_blk_pattern <= '0;
         r_blk_n       <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_id      <= '0;
         r_out_last    <= 1'b0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_req_ready <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            IDLE: begin
               // The done cycle is spent idle so the next grant lands one cycle later.
               if (w_any && !r_done) begin
                  r_req_ready   <= w_grant;
                  r_ptr         <= w_idx;
                  r_blk_pattern <= w_pat[w_idx];
                  r_blk_n       <= w_n[w_idx];
                  r_len_cnt     <= w_len[w_idx];
                  r_rst_cnt     <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= RESTART;
               end
            end
            RESTART: begin
               if (r_rst_cnt == RST_LAST) begin
                  r_rst_cnt <= '0;
                  if (r_len_cnt == '0) begin
                     r_state <= DONE;
                  end else if (PIPE_LAT == 0) begin
                     r_blk_rst <= 1'b0;
                     r_state   <= RUN;
                  end else begin
                     r_blk_rst  <= 1'b0;
                     r_wait_cnt <= '0;
                     r_state    <= WAIT;
                  end
               end else begin
                  r_rst_cnt <= r_rst_cnt + RST_W'(1);
               end
            end
            WAIT: begin
               if (w_abort) begin
                  r_blk_rst <= 1'b1;
                  r_state   <= DONE;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state <= RUN;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            RUN: begin
               r_out_valid <= 1'b1;
               r_out_data  <= i_blk_data;
               r_out_id    <= r_ptr;
               r_len_cnt   <= r_len_cnt - LEN_W'(1);
               if (r_len_cnt == LEN_W'(1) || w_abort) begin
                  r_out_last <= 1'b1;
                  r_blk_rst  <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_blk_rst     = r_blk_rst;
   assign o_blk_pattern = r_blk_pattern;
   assign o_blk_n       = r_blk_n;
   assign o_out_valid   = r_out_valid;
   assign o_out_data    = r_out_data;
   assign o_out_id      = r_out_id;
   assign o_out_last    = r_out_last;
   assign o_done        = r_done;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_prbs_burst_sched.sv
// Scoreboard bench for prbs_burst_sched with a counting stand-in for the PRBS datapath.
module tb_prbs_burst_sched;

   localparam int NUM_REQ = 2;
   localparam int LEN_W   = 16;
   localparam int IDX_W   = 1;

   typedef struct packed {
      logic [7:0]       data;
      logic [IDX_W-1:0] id;
      logic             last;
   } exp_t;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [32*NUM_REQ-1:0]    req_pattern;
   logic [4*NUM_REQ-1:0]     req_n;
   logic [LEN_W*NUM_REQ-1:0] req_len;
   logic                     abort;
   logic [7:0]               blk_data;
   logic [7:0]               dp_cnt;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic                     o_blk_rst;
   logic [31:0]              o_blk_pattern;
   logic [3:0]               o_blk_n;
   logic                     o_out_valid;
   logic [7:0]               o_out_data;
   logic [IDX_W-1:0]         o_out_id;
   logic                     o_out_last;
   logic                     o_done;
   logic                     o_busy;

   exp_t exp_q[$];
   int   exp_grant_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   int   bytes_seen = 0;
   int   done_count = 0;
   int   ready_cycle = 0;
   bit   first_pending = 0;
   bit   prev_last = 0;
   bit   zl_allow = 0;

   prbs_burst_sched #(
      .NUM_REQ  (NUM_REQ),
      .LEN_W    (LEN_W),
      .PIPE_LAT (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .i_req_pattern (req_pattern),
      .i_req_n       (req_n),
      .i_req_len     (req_len),
`ifdef PRBS_BURST_SCHED_ABORT_EN
      .i_abort       (abort),
`endif
      .i_blk_data    (blk_data),
      .o_req_ready   (o_req_ready),
      .o_blk_rst     (o_blk_rst),
      .o_blk_pattern (o_blk_pattern),
      .o_blk_n       (o_blk_n),
      .o_out_valid   (o_out_valid),
      .o_out_data    (o_out_data),
      .o_out_id      (o_out_id),
      .o_out_last    (o_out_last),
      .o_done        (o_done),
      .o_busy        (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Datapath stand-in: counts cycles since restart release, offset by the pattern low byte.
   always @(posedge clk) begin
      if (o_blk_rst) dp_cnt <= 8'd0;
      else           dp_cnt <= dp_cnt + 8'd1;
   end
   assign blk_data = o_blk_pattern[7:0] + dp_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cycle);
   endtask

   task automatic push_burst(input logic [7:0] first, input int id, input int len);
      exp_t e;
      for (int k = 0; k < len; k++) begin
         e.data = first + 8'(k);
         e.id   = IDX_W'(id);
         e.last = (k == len - 1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: pops grants and bytes from the scoreboard whenever the DUT presents them.
   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (!rst_n) begin
         prev_last     = 0;
         first_pending = 0;
      end else begin
         if (o_req_ready != '0) begin
            if (exp_grant_q.size() == 0) fail_now("unexpected_grant");
            else begin
               g = exp_grant_q.pop_front();
               chk("grant_onehot", 32'(o_req_ready), 32'(1) << g);
            end
            ready_cycle   = cycle;
            first_pending = 1;
         end
         if (prev_last) begin
            chk("done_after_last", 32'(o_done), 32'd1);
            chk("valid_off_after_last", 32'(o_out_valid), 32'd0);
         end else if (o_done && !zl_allow) begin
            fail_now("unexpected_done");
         end
         if (o_done) done_count++;
         if (o_out_valid) begin
            bytes_seen++;
            if (first_pending) begin
               chk("first_byte_latency", 32'(cycle - ready_cycle), 32'd4);
               first_pending = 0;
            end
            if (exp_q.size() == 0) fail_now("unexpected_byte");
            else begin
               e = exp_q.pop_front();
               $display("[TB] byte data=%02h id=%0d last=%0d", o_out_data, o_out_id, o_out_last);
               chk("byte_data", 32'(o_out_data), 32'(e.data));
               chk("byte_id", 32'(o_out_id), 32'(e.id));
               chk("byte_last", 32'(o_out_last), 32'(e.last));
            end
         end
         prev_last = o_out_valid && o_out_last;
      end
   end

   task automatic set_job(input int id, input logic [31:0] pat, input logic [3:0] n,
                          input logic [LEN_W-1:0] len);
      req_pattern[id*32 +: 32]      = pat;
      req_n[id*4 +: 4]              = n;
      req_len[id*LEN_W +: LEN_W]    = len;
   endtask

   // Returns one ns after the negedge of the cycle showing req_ready[id].
   task automatic post(input int id, input logic [31:0] pat, input logic [3:0] n,
                       input logic [LEN_W-1:0] len);
      bit ok;
      set_job(id, pat, n, len);
      req_valid[id] = 1'b1;
      ok = 0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk); #1;
         if (o_req_ready[id]) ok = 1;
      end
      req_valid[id] = 1'b0;
      if (!ok) fail_now("accept_timeout");
      $display("[TB] job req=%0d pattern=%08h n=%0d len=%0d accepted=%0d", id, pat, n, len, ok);
   endtask

   task automatic wait_done();
      int base;
      bit ok;
      base = done_count;
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk); #1;
         if (done_count > base) ok = 1;
      end
      if (!ok) fail_now("done_timeout");
   endtask

   task automatic wait_bytes(input int target);
      bit ok;
      ok = 0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk); #1;
         if (bytes_seen >= target) ok = 1;
      end
      if (!ok) fail_now("byte_timeout");
   endtask

   initial begin
      int gcount;
      int d0;
      rst_n = 1'b0;
      req_valid = '0;
      req_pattern = '0;
      req_n = '0;
      req_len = '0;
      abort = 1'b0;
      #12;
      chk("rst_req_ready", 32'(o_req_ready), 32'd0);
      chk("rst_blk_rst", 32'(o_blk_rst), 32'd1);
      chk("rst_blk_pattern", o_blk_pattern, 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Single job on requester 0
      exp_grant_q.push_back(0);
      push_burst(8'hA9, 0, 8);
      post(0, 32'hA5A6A7A8, 4'd4, 16'd8);
      chk("t1_blk_rst_g1", 32'(o_blk_rst), 32'd1);
      chk("t1_blk_pattern", o_blk_pattern, 32'hA5A6A7A8);
      chk("t1_blk_n", 32'(o_blk_n), 32'd4);
      chk("t1_busy", 32'(o_busy), 32'd1);
      @(negedge clk); #1;
      chk("t1_blk_rst_g2", 32'(o_blk_rst), 32'd1);
      @(negedge clk); #1;
      chk("t1_blk_rst_release", 32'(o_blk_rst), 32'd0);
      wait_done();
      chk("t1_busy_at_done", 32'(o_busy), 32'd0);

      // Zero-length job on requester 1
      zl_allow = 1;
      exp_grant_q.push_back(1);
      post(1, 32'h000000C0, 4'd1, 16'd0);
      for (int k = 0; k < 3; k++) begin
         chk("zl_blk_rst_high", 32'(o_blk_rst), 32'd1);
         chk("zl_no_valid", 32'(o_out_valid), 32'd0);
         @(negedge clk); #1;
      end
      chk("zl_done", 32'(o_done), 32'd1);
      chk("zl_busy_low", 32'(o_busy), 32'd0);
      @(negedge clk); #1;
      zl_allow = 0;

      // Fairness: both requesters held valid, expect 0,1,0,1
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
      push_burst(8'h11, 0, 3);
      push_burst(8'h41, 1, 3);
      push_burst(8'h11, 0, 3);
      push_burst(8'h41, 1, 3);
      set_job(0, 32'h00000010, 4'd2, 16'd3);
      set_job(1, 32'h00000040, 4'd3, 16'd3);
      d0 = done_count;
      req_valid = 2'b11;
      gcount = 0;
      for (int c = 0; c < 200 && gcount < 4; c++) begin
         @(negedge clk); #1;
         if (o_req_ready != '0) gcount++;
      end
      req_valid = '0;
      if (gcount < 4) fail_now("fair_grant_timeout");
      $display("[TB] fairness grants observed=%0d", gcount);
      for (int c = 0; c < 60 && done_count < d0 + 4; c++) begin
         @(negedge clk); #1;
      end
      chk("fair_done_count", 32'(done_count - d0), 32'd4);
      @(negedge clk); #1;

      // Config hold: previous job values persist, then new job stays stable
      chk("hold_prev_pattern", o_blk_pattern, 32'h00000040);
      chk("hold_prev_n", 32'(o_blk_n), 32'd3);
      exp_grant_q.push_back(0);
      push_burst(8'h5B, 0, 2);
      post(0, 32'h5A5A5A5A, 4'd8, 16'd2);
      for (int c = 0; c < 30; c++) begin
         chk("hold_pattern", o_blk_pattern, 32'h5A5A5A5A);
         chk("hold_n", 32'(o_blk_n), 32'd8);
         if (o_done) break;
         @(negedge clk); #1;
      end
      @(negedge clk); #1;

      // Reset in the middle of a 10-byte burst
      exp_grant_q.push_back(1);
      push_burst(8'h21, 1, 3);
      exp_q[2].last = 1'b0;
      d0 = bytes_seen;
      post(1, 32'h00000020, 4'd5, 16'd10);
      wait_bytes(d0 + 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", 32'(o_req_ready), 32'd0);
      chk("mid_rst_blk_rst", 32'(o_blk_rst), 32'd1);
      chk("mid_rst_blk_pattern", o_blk_pattern, 32'd0);
      chk("mid_rst_blk_n", 32'(o_blk_n), 32'd0);
      chk("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(o_out_data), 32'd0);
      chk("mid_rst_out_id", 32'(o_out_id), 32'd0);
      chk("mid_rst_out_last", 32'(o_out_last), 32'd0);
      chk("mid_rst_done", 32'(o_done), 32'd0);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk); #1;
      exp_grant_q.push_back(0);
      push_burst(8'h71, 0, 2);
      post(0, 32'h00000070, 4'd1, 16'd2);
      wait_done();

`ifdef PRBS_BURST_SCHED_ABORT_EN
      // Abort while byte 2 of a 10-byte burst is on the output
      exp_grant_q.push_back(1);
      push_burst(8'h31, 1, 3);
      d0 = bytes_seen;
      post(1, 32'h00000030, 4'd2, 16'd10);
      wait_bytes(d0 + 2);
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      @(negedge clk); #1;
      chk("abort_done", 32'(o_done), 32'd1);
      chk("abort_busy_low", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("abort_bytes", 32'(bytes_seen - d0), 32'd3);
`endif

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
      $fatal(1, "watchdog");
   end

endmodule
